// File: rtl/snake_pkg.sv
// Shared definitions for the snake target generator: coordinate widths,
// default grid limits, play-state encodings and the target FSM encoding.
package snake_pkg;

  localparam int XW = 8;
  localparam int YW = 7;

  localparam logic [XW-1:0] MAX_X_DEF = 8'd159;
  localparam logic [YW-1:0] MAX_Y_DEF = 7'd119;

  typedef enum logic [1:0] {
    PS_START = 2'b00,
    PS_PLAY  = 2'b01,
    PS_WIN   = 2'b10,
    PS_LOSE  = 2'b11
  } play_state_e;

  typedef enum logic {
    ST_HOLD   = 1'b0,
    ST_SEARCH = 1'b1
  } tgt_state_e;

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Fibonacci LFSR. Shifts left every clock; the new LSB is the
// XOR of the bits selected by TapMask. A nonzero seed keeps it off zero.
module lfsr_gen
  import snake_pkg::*;
#(
  parameter int               Width   = XW,
  parameter logic [Width-1:0] TapMask = 8'hB8,
  parameter logic [Width-1:0] Seed    = 8'hB5
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic [Width-1:0] Value
);

  logic [Width-1:0] lfsr_q;
  logic [Width-1:0] lfsr_d;

  // Next LFSR value: shift left and feed the tap parity into bit 0.
  always_comb begin
    lfsr_d = {lfsr_q[Width-2:0], ^(lfsr_q & TapMask)};
  end

  // LFSR register, returns to the seed on reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign Value = lfsr_q;

endmodule

// File: rtl/snake_target_generator.sv
// Fruit target generator for the snake game. Holds a live target, and on a
// Reached_Target pulse during play draws a new one from two LFSRs, rejecting
// draws that fall outside the grid. Also keeps the saturating score and win flag.
module snake_target_generator
  import snake_pkg::*;
#(
  parameter logic [XW-1:0] MaxX     = MAX_X_DEF,
  parameter logic [YW-1:0] MaxY     = MAX_Y_DEF,
  parameter logic [XW-1:0] InitX    = 8'd100,
  parameter logic [YW-1:0] InitY    = 7'd60,
  parameter logic [XW-1:0] SeedX    = 8'hB5,
  parameter logic [YW-1:0] SeedY    = 7'h2A,
  parameter logic [7:0]    WinScore = 8'd10
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          Reached_Target,
  input  logic [1:0]    Play_State,
  output logic [XW-1:0] Random_Target_X,
  output logic [YW-1:0] Random_Target_Y,
  output logic          Target_Valid,
  output logic [7:0]    Score,
  output logic          Win
);

  logic [XW-1:0] lfsr_x;
  logic [YW-1:0] lfsr_y;
  logic          draw_ok;

  tgt_state_e    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [7:0]    score_q, score_d;

  // x^8+x^6+x^5+x^4+1 -> taps on bits 7,5,4,3.
  lfsr_gen #(
    .Width  (XW),
    .TapMask(8'hB8),
    .Seed   (SeedX)
  ) u_lfsr_x (
    .CLK  (CLK),
    .RESET(RESET),
    .Value(lfsr_x)
  );

  // x^7+x^6+1 -> taps on bits 6,5.
  lfsr_gen #(
    .Width  (YW),
    .TapMask(7'h60),
    .Seed   (SeedY)
  ) u_lfsr_y (
    .CLK  (CLK),
    .RESET(RESET),
    .Value(lfsr_y)
  );

  assign draw_ok = (lfsr_x <= MaxX) && (lfsr_y <= MaxY);

  // Next-state logic: start state clears everything, otherwise HOLD waits for
  // a scoring pulse and SEARCH latches the first in-range LFSR draw.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    score_d = score_q;
    if (Play_State == PS_START) begin
      state_d = ST_HOLD;
      x_d     = InitX;
      y_d     = InitY;
      score_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (Reached_Target && (Play_State == PS_PLAY)) begin
            state_d = ST_SEARCH;
            if (score_q < WinScore) begin
              score_d = score_q + 8'd1;
            end
          end
        end
        ST_SEARCH: begin
          if (draw_ok) begin
            x_d     = lfsr_x;
            y_d     = lfsr_y;
            state_d = ST_HOLD;
          end
        end
        default: state_d = ST_HOLD;
      endcase
    end
  end

  // State, target and score registers with asynchronous reset to the init target.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_HOLD;
      x_q     <= InitX;
      y_q     <= InitY;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      score_q <= score_d;
    end
  end

  assign Random_Target_X = x_q;
  assign Random_Target_Y = y_q;
  assign Target_Valid    = (state_q == ST_HOLD);
  assign Score           = score_q;
  assign Win             = (score_q == WinScore);

endmodule

// File: tb/tb_snake_target_generator.sv
// Self-checking bench for snake_target_generator. A reference LFSR pair runs
// alongside the DUT; each accepted pulse pushes the predicted target and
// search latency onto a scoreboard that is popped when Target_Valid returns.
module tb_snake_target_generator;

  localparam logic [7:0] INIT_X    = 8'd100;
  localparam logic [6:0] INIT_Y    = 7'd60;
  localparam logic [7:0] MAX_X     = 8'd159;
  localparam logic [6:0] MAX_Y     = 7'd119;
  localparam logic [7:0] WIN_SCORE = 8'd10;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    int         lat;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       Reached_Target;
  logic [1:0] Play_State;
  logic [7:0] Random_Target_X;
  logic [6:0] Random_Target_Y;
  logic       Target_Valid;
  logic [7:0] Score;
  logic       Win;

  logic [7:0] model_x;
  logic [6:0] model_y;
  logic [7:0] sb_score;
  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;

  snake_target_generator dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .Reached_Target (Reached_Target),
    .Play_State     (Play_State),
    .Random_Target_X(Random_Target_X),
    .Random_Target_Y(Random_Target_Y),
    .Target_Valid   (Target_Valid),
    .Score          (Score),
    .Win            (Win)
  );

  // 10 ns clock.
  always #5 CLK = ~CLK;

  function automatic logic [7:0] step_x(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [6:0] step_y(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  // Reference LFSRs, reset and stepped exactly like the hardware ones.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      model_x <= 8'hB5;
      model_y <= 7'h2A;
    end else begin
      model_x <= step_x(model_x);
      model_y <= step_y(model_y);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) tick();
    checks++;
    if ({Random_Target_X, Random_Target_Y, Target_Valid, Score, Win} !==
        {INIT_X, INIT_Y, 1'b1, 8'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_values got x=%0d y=%0d v=%b s=%0d w=%b want 100/60/1/0/0",
               Random_Target_X, Random_Target_Y, Target_Valid, Score, Win);
    end
    RESET = 1'b0;
    repeat (2) tick();
    checks++;
    if ({Random_Target_X, Random_Target_Y, Target_Valid, Score, Win} !==
        {INIT_X, INIT_Y, 1'b1, 8'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL start_hold got x=%0d y=%0d v=%b s=%0d w=%b want 100/60/1/0/0",
               Random_Target_X, Random_Target_Y, Target_Valid, Score, Win);
    end
    sb_score = 8'd0;
  endtask

  // One accepted pulse from HOLD; hold_two keeps the pulse high into SEARCH.
  task automatic do_relocate(input bit hold_two);
    logic [7:0] px;
    logic [6:0] py;
    int         lat;
    int         waited;
    bit         bad;
    exp_t       e;
    px  = model_x;
    py  = model_y;
    lat = 0;
    do begin
      px = step_x(px);
      py = step_y(py);
      lat++;
    end while (!((px <= MAX_X) && (py <= MAX_Y)) && (lat < 256));
    sb_q.push_back('{x: px, y: py, lat: lat});
    if (sb_score < WIN_SCORE) sb_score = sb_score + 8'd1;

    Reached_Target = 1'b1;
    tick();
    Reached_Target = hold_two;
    checks++;
    if ({Target_Valid, Score, Win} !== {1'b0, sb_score, (sb_score == WIN_SCORE)}) begin
      errors++;
      $display("[TB] FAIL enter_search got v=%b s=%0d w=%b want v=0 s=%0d w=%b",
               Target_Valid, Score, Win, sb_score, (sb_score == WIN_SCORE));
    end

    waited = 0;
    bad    = 1'b0;
    while ((Target_Valid !== 1'b1) && (waited < 64)) begin
      if ((Random_Target_X > MAX_X) || (Random_Target_Y > MAX_Y) ||
          (Random_Target_X == 8'd0) || (Random_Target_Y == 7'd0)) bad = 1'b1;
      tick();
      Reached_Target = 1'b0;
      waited++;
    end
    if ((Random_Target_X > MAX_X) || (Random_Target_Y > MAX_Y) ||
        (Random_Target_X == 8'd0) || (Random_Target_Y == 7'd0)) bad = 1'b1;

    checks++;
    if (Target_Valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL search_timeout got v=%b after %0d cycles want v=1", Target_Valid, waited);
    end
    e = sb_q.pop_front();
    checks++;
    if ({Random_Target_X, Random_Target_Y} !== {e.x, e.y}) begin
      errors++;
      $display("[TB] FAIL new_target got x=%0d y=%0d want x=%0d y=%0d",
               Random_Target_X, Random_Target_Y, e.x, e.y);
    end
    checks++;
    if (waited !== e.lat) begin
      errors++;
      $display("[TB] FAIL search_latency got %0d want %0d", waited, e.lat);
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("[TB] FAIL out_of_range got bad=%b want 0", bad);
    end
    checks++;
    if ({Score, Win} !== {sb_score, (sb_score == WIN_SCORE)}) begin
      errors++;
      $display("[TB] FAIL score_after got s=%0d w=%b want s=%0d w=%b",
               Score, Win, sb_score, (sb_score == WIN_SCORE));
    end
  endtask

  task automatic test_single_relocation();
    Play_State = 2'b01;
    tick();
    do_relocate(1'b0);
  endtask

  task automatic test_back_to_back();
    do_relocate(1'b1);
  endtask

  task automatic test_ignored_lose();
    logic [7:0] ox;
    logic [6:0] oy;
    ox = Random_Target_X;
    oy = Random_Target_Y;
    Play_State     = 2'b11;
    Reached_Target = 1'b1;
    tick();
    Reached_Target = 1'b0;
    tick();
    checks++;
    if ({Target_Valid, Score, Random_Target_X, Random_Target_Y} !== {1'b1, sb_score, ox, oy}) begin
      errors++;
      $display("[TB] FAIL ignored_lose got v=%b s=%0d x=%0d y=%0d want v=1 s=%0d x=%0d y=%0d",
               Target_Valid, Score, Random_Target_X, Random_Target_Y, sb_score, ox, oy);
    end
    Play_State = 2'b01;
  endtask

  task automatic test_start_priority();
    Play_State     = 2'b00;
    Reached_Target = 1'b1;
    tick();
    Reached_Target = 1'b0;
    sb_score       = 8'd0;
    checks++;
    if ({Random_Target_X, Random_Target_Y, Target_Valid, Score, Win} !==
        {INIT_X, INIT_Y, 1'b1, 8'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL start_priority got x=%0d y=%0d v=%b s=%0d w=%b want 100/60/1/0/0",
               Random_Target_X, Random_Target_Y, Target_Valid, Score, Win);
    end
    Play_State = 2'b01;
    tick();
  endtask

  task automatic test_win();
    for (int i = 0; i < 11; i++) begin
      do_relocate(1'b0);
      tick();
    end
    checks++;
    if ({Score, Win} !== {WIN_SCORE, 1'b1}) begin
      errors++;
      $display("[TB] FAIL win_saturate got s=%0d w=%b want s=10 w=1", Score, Win);
    end
  endtask

  task automatic test_async_reset_search();
    Reached_Target = 1'b1;
    tick();
    Reached_Target = 1'b0;
    checks++;
    if (Target_Valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_pre got v=%b want 0", Target_Valid);
    end
    #2;
    RESET = 1'b1;
    #1;
    checks++;
    if ({Random_Target_X, Random_Target_Y, Target_Valid, Score, Win} !==
        {INIT_X, INIT_Y, 1'b1, 8'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL async_reset got x=%0d y=%0d v=%b s=%0d w=%b want 100/60/1/0/0",
               Random_Target_X, Random_Target_Y, Target_Valid, Score, Win);
    end
    RESET = 1'b0;
    sb_q.delete();
    sb_score = 8'd0;
    tick();
    checks++;
    if ({Random_Target_X, Random_Target_Y, Target_Valid, Score} !==
        {INIT_X, INIT_Y, 1'b1, 8'd0}) begin
      errors++;
      $display("[TB] FAIL no_pending_draw got x=%0d y=%0d v=%b s=%0d want 100/60/1/0",
               Random_Target_X, Random_Target_Y, Target_Valid, Score);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      do_relocate(1'($urandom_range(0, 1)));
    end
  endtask

  // Test sequence.
  initial begin
    RESET          = 1'b0;
    Reached_Target = 1'b0;
    Play_State     = 2'b00;
    sb_score       = 8'd0;
    #2;
    test_reset();
    test_single_relocation();
    test_back_to_back();
    test_ignored_lose();
    test_start_priority();
    test_win();
    test_async_reset_search();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
